// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, one held instruction,
// PC updated from the execute stage when the held instruction retires.
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif

module ifu_fetch #(
    parameter logic [`ISA_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [`ISA_WIDTH-1:0] pc_in,
    input  logic                  pc_w_en,
    output logic [`ISA_WIDTH-1:0] pc_out,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [`ISA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [`ISA_WIDTH-1:0] imem_resp_data,
    input  logic                  imem_resp_err,
    output logic [`ISA_WIDTH-1:0] inst,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic                  halted,
    output logic                  fetch_err
);
    localparam int W = `ISA_WIDTH;

    typedef enum logic [2:0] {S_REQ, S_WAIT, S_VALID, S_HALT, S_ERR} state_t;

    state_t         r_state, w_next;
    logic [W-1:0]   r_pc, r_inst;
    logic           w_retire, w_pc_ok, w_capture;

    assign w_retire  = (r_state == S_VALID) && inst_ready;
    assign w_pc_ok   = (pc_in[1:0] == 2'b00);
    assign w_capture = (r_state == S_WAIT) && imem_resp_valid && !imem_resp_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_REQ:   if (imem_req_ready) w_next = S_WAIT;
            S_WAIT:  if (imem_resp_valid) w_next = imem_resp_err ? S_ERR : S_VALID;
            S_VALID: begin
                if (inst_ready) begin
                    if (!pc_w_en)     w_next = S_HALT;
                    else if (w_pc_ok) w_next = S_REQ;
                    else              w_next = S_ERR;
                end
            end
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire && pc_w_en && w_pc_ok) r_pc <= pc_in;
            if (w_capture) r_inst <= imem_resp_data;
        end
    end

    // Reset forces REQ asynchronously, so masking with rst keeps the bus quiet during reset.
    assign imem_req_valid = (r_state == S_REQ) && !rst;
    assign imem_req_addr  = r_pc;
    assign pc_out         = r_pc;
    assign inst           = r_inst;
    assign inst_valid     = (r_state == S_VALID);
    assign halted         = (r_state == S_HALT);
    assign fetch_err      = (r_state == S_ERR);

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch; accepted requests and consumed instructions
// are checked by a monitor against queues filled by the stimulus.
`timescale 1ns/1ps

module tb_ifu_fetch;
    logic        clk, rst;
    logic [31:0] pc_in;
    logic        pc_w_en;
    logic [31:0] pc_out;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic [31:0] inst;
    logic        inst_valid, inst_ready;
    logic        halted, fetch_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] q_req[$];
    logic [31:0] q_inst[$];

    ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_w_en(pc_w_en), .pc_out(pc_out),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .halted(halted), .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted request and every consumed instruction must be expected.
    always @(negedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) begin
            if (q_req.size() == 0) check("unexpected_req", imem_req_addr, 32'hxxxx_xxxx);
            else check("req_addr", imem_req_addr, q_req.pop_front());
        end
        if (!rst && inst_valid && inst_ready) begin
            if (q_inst.size() == 0) check("unexpected_inst", inst, 32'hxxxx_xxxx);
            else check("inst_out", inst, q_inst.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
        imem_resp_data = '0; inst_ready = 1'b0; pc_w_en = 1'b0; pc_in = '0;
        tick(); tick();
        imem_req_ready = 1'b0;
        rst = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input bit err, input int stall);
        int n = 0;
        while (!imem_req_valid && n < 8) begin tick(); n++; end
        check("req_valid_seen", {31'b0, imem_req_valid}, 32'd1);
        q_req.push_back(addr);
        imem_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", {31'b0, imem_req_valid}, 32'd1);
            check("stall_addr", imem_req_addr, addr);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
        imem_resp_valid = 1'b1; imem_resp_data = data; imem_resp_err = err;
        tick();
        imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
        if (!err) begin
            check("inst_valid", {31'b0, inst_valid}, 32'd1);
            check("inst_data", inst, data);
            q_inst.push_back(data);
        end
    endtask

    task automatic retire(input logic [31:0] pc, input bit wen);
        pc_in = pc; pc_w_en = wen; inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0; pc_w_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        do_reset();
        // Reset state, then release with an immediate first request.
        check("rst_pc", pc_out, 32'h8000_0000);
        check("rst_inst", inst, 32'h0);
        check("rst_flags", {28'b0, inst_valid, halted, fetch_err, 1'b0}, 32'h0);
        check("first_req_addr", imem_req_addr, 32'h8000_0000);
        fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 0);

        // Downstream stall: inst held; stray responses and pc writes ignored.
        for (int i = 0; i < 5; i++) begin
            imem_resp_valid = 1'b1; imem_resp_data = 32'hFFFF_FFFF;
            pc_w_en = 1'b1; pc_in = 32'h0000_1234;
            tick();
            check("hold_inst", inst, 32'h0000_0413);
            check("hold_pc", pc_out, 32'h8000_0000);
        end
        imem_resp_valid = 1'b0; pc_w_en = 1'b0;
        check("hold_valid", {31'b0, inst_valid}, 32'd1);

        retire(32'h8000_0004, 1'b1);
        check("seq_pc", pc_out, 32'h8000_0004);
        fetch(32'h8000_0004, 32'h0010_0093, 1'b0, 3);
        retire(32'h8000_0100, 1'b1);
        check("branch_pc", pc_out, 32'h8000_0100);
        fetch(32'h8000_0100, 32'h0010_0073, 1'b0, 0);

        // Halt on retire without a PC write.
        retire(32'h1234_5678, 1'b0);
        check("halted", {31'b0, halted}, 32'd1);
        check("halt_pc", pc_out, 32'h8000_0100);
        imem_req_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid) seen++;
            tick();
        end
        imem_req_ready = 1'b0;
        check("halt_no_req", seen, 0);
        check("halt_sticky", {31'b0, halted}, 32'd1);

        // Misaligned next PC.
        do_reset();
        fetch(32'h8000_0000, 32'h0000_0013, 1'b0, 0);
        retire(32'h8000_0002, 1'b1);
        check("mis_err", {31'b0, fetch_err}, 32'd1);
        check("mis_pc", pc_out, 32'h8000_0000);
        check("mis_inst_valid", {31'b0, inst_valid}, 32'd0);
        imem_req_ready = 1'b1;
        tick(); tick();
        check("mis_no_req", {31'b0, imem_req_valid}, 32'd0);
        imem_req_ready = 1'b0;

        // Access fault on the response.
        do_reset();
        fetch(32'h8000_0000, 32'h0BAD_0BAD, 1'b1, 0);
        check("resp_err", {31'b0, fetch_err}, 32'd1);
        check("resp_err_inst", inst, 32'h0);
        check("resp_err_valid", {31'b0, inst_valid}, 32'd0);

        // Reset mid-WAIT, response arriving on release is dropped.
        do_reset();
        fetch(32'h8000_0000, 32'h0000_0013, 1'b0, 0);
        retire(32'h8000_0004, 1'b1);
        q_req.push_back(32'h8000_0004);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("midwait_rst_pc", pc_out, 32'h8000_0000);
        check("midwait_rst_req", {31'b0, imem_req_valid}, 32'd0);
        tick();
        rst = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        check("late_resp_valid", {31'b0, inst_valid}, 32'd0);
        check("late_resp_inst", inst, 32'h0);
        check("fresh_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("fresh_req_addr", imem_req_addr, 32'h8000_0000);
        fetch(32'h8000_0000, 32'h0050_0093, 1'b0, 0);
        retire(32'h8000_0004, 1'b1);
        tick();

        check("req_queue_drained", q_req.size(), 0);
        check("inst_queue_drained", q_inst.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
